// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single debug-memory port between the controller (side 0) and the core (side 1).
// One command slot per side, round-robin or controller-only grant, timed memory handshake, one-cycle response.
module memory_bus_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 360
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ctrl_lock,
  input  logic                 i_ctrl_read,
  input  logic                 i_ctrl_write,
  input  logic [BUS_WIDTH-1:0] i_ctrl_address,
  input  logic [BUS_WIDTH-1:0] i_ctrl_write_data,
  output logic                 o_ctrl_busy,
  output logic                 o_ctrl_response,
  output logic [BUS_WIDTH-1:0] o_ctrl_read_data,
  input  logic                 i_core_read,
  input  logic                 i_core_write,
  input  logic [BUS_WIDTH-1:0] i_core_address,
  input  logic [BUS_WIDTH-1:0] i_core_write_data,
  output logic                 o_core_busy,
  output logic                 o_core_response,
  output logic [BUS_WIDTH-1:0] o_core_read_data,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [BUS_WIDTH-1:0] o_mem_address,
  output logic [BUS_WIDTH-1:0] o_mem_write_data,
  input  logic [BUS_WIDTH-1:0] i_mem_read_data,
  input  logic                 i_mem_response,
  output logic                 o_mux_selector,
  output logic                 o_timeout_error
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic [1:0]           w_cmd_rd, w_cmd_wr, w_pend, w_is_wr, w_resp, w_busy;
  logic [BUS_WIDTH-1:0] w_cmd_addr  [2];
  logic [BUS_WIDTH-1:0] w_cmd_data  [2];
  logic [BUS_WIDTH-1:0] w_slot_addr [2];
  logic [BUS_WIDTH-1:0] w_slot_data [2];
  logic [BUS_WIDTH-1:0] w_rdata     [2];
  logic                 w_grant, w_grant_side, w_done, w_abort;

  logic                 r_winner, r_last, r_mem_read, r_mem_write, r_mux, r_timeout_error;
  logic [BUS_WIDTH-1:0] r_mem_address, r_mem_write_data;
  logic [TW-1:0]        r_timer;

  assign w_cmd_rd      = {i_core_read, i_ctrl_read};
  assign w_cmd_wr      = {i_core_write, i_ctrl_write};
  assign w_cmd_addr[0] = i_ctrl_address;
  assign w_cmd_addr[1] = i_core_address;
  assign w_cmd_data[0] = i_ctrl_write_data;
  assign w_cmd_data[1] = i_core_write_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_side = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Lock masks the core entirely; otherwise a tie goes to whoever was not served last.
        if (w_pend[0]) begin
          w_grant      = 1'b1;
          w_grant_side = (!i_ctrl_lock && w_pend[1]) ? ~r_last : 1'b0;
        end else if (w_pend[1] && !i_ctrl_lock) begin
          w_grant      = 1'b1;
          w_grant_side = 1'b1;
        end
        if (w_grant) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (i_mem_response) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end else if (r_timer == TIMER_MAX) begin
          w_abort      = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic                 r_pend, r_is_wr;
    logic [BUS_WIDTH-1:0] r_addr, r_wdata, r_rdata;

    assign w_resp[gi]      = (r_state == S_RESP) && (r_winner == 1'(gi));
    // The winning slot reads as free during its response cycle so a new pulse there is accepted.
    assign w_busy[gi]      = r_pend && !w_resp[gi];
    assign w_pend[gi]      = r_pend;
    assign w_is_wr[gi]     = r_is_wr;
    assign w_slot_addr[gi] = r_addr;
    assign w_slot_data[gi] = r_wdata;
    assign w_rdata[gi]     = r_rdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_pend  <= 1'b0;
        r_is_wr <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_rdata <= '0;
      end else begin
        if ((w_cmd_rd[gi] || w_cmd_wr[gi]) && !w_busy[gi]) begin
          r_pend  <= 1'b1;
          r_is_wr <= w_cmd_wr[gi];
          r_addr  <= w_cmd_addr[gi];
          r_wdata <= w_cmd_data[gi];
        end else if (w_resp[gi]) begin
          r_pend  <= 1'b0;
        end
        if (w_done && r_winner == 1'(gi) && !r_is_wr) r_rdata <= i_mem_read_data;
        else if (w_abort && r_winner == 1'(gi))      r_rdata <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_winner         <= 1'b0;
      r_last           <= 1'b1;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mux            <= 1'b0;
      r_timeout_error  <= 1'b0;
      r_timer          <= '0;
    end else begin
      if (w_grant) begin
        r_winner         <= w_grant_side;
        r_mux            <= w_grant_side;
        r_mem_address    <= w_slot_addr[w_grant_side];
        r_mem_write_data <= w_slot_data[w_grant_side];
        r_mem_write      <= w_is_wr[w_grant_side];
        r_mem_read       <= !w_is_wr[w_grant_side];
        r_timer          <= '0;
      end else if (w_done || w_abort) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (w_abort) r_timeout_error <= 1'b1;
      end else if (r_state == S_BUSY) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == S_RESP) r_last <= r_winner;
    end
  end

  assign o_ctrl_busy      = w_busy[0];
  assign o_core_busy      = w_busy[1];
  assign o_ctrl_response  = w_resp[0];
  assign o_core_response  = w_resp[1];
  assign o_ctrl_read_data = w_rdata[0];
  assign o_core_read_data = w_rdata[1];
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mux_selector   = r_mux;
  assign o_timeout_error  = r_timeout_error;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: behavioural memory, per-side response scoreboards.
module tb_memory_bus_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_lock, ctrl_read, ctrl_write, core_read, core_write;
  logic [W-1:0] ctrl_address, ctrl_write_data, core_address, core_write_data;
  logic         ctrl_busy, ctrl_response, core_busy, core_response;
  logic [W-1:0] ctrl_read_data, core_read_data;
  logic         mem_read, mem_write, mem_response, mux_selector, timeout_error;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(360)) dut (
    .i_clk(clk), .i_reset(rst), .i_ctrl_lock(ctrl_lock),
    .i_ctrl_read(ctrl_read), .i_ctrl_write(ctrl_write),
    .i_ctrl_address(ctrl_address), .i_ctrl_write_data(ctrl_write_data),
    .o_ctrl_busy(ctrl_busy), .o_ctrl_response(ctrl_response), .o_ctrl_read_data(ctrl_read_data),
    .i_core_read(core_read), .i_core_write(core_write),
    .i_core_address(core_address), .i_core_write_data(core_write_data),
    .o_core_busy(core_busy), .o_core_response(core_response), .o_core_read_data(core_read_data),
    .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
    .i_mem_read_data(mem_read_data), .i_mem_response(mem_response),
    .o_mux_selector(mux_selector), .o_timeout_error(timeout_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural memory: answers mem_delay cycles after the strobe rises, unless disabled.
  logic [W-1:0] mem [logic [W-1:0]];
  logic [W-1:0] addr_log [$];
  int           mem_delay  = 3;
  bit           mem_enable = 1'b1;
  int           hi_cnt     = 0;

  function automatic logic [W-1:0] model_read(logic [W-1:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  always @(negedge clk) begin
    if (!rst && (mem_read || mem_write)) begin
      if (hi_cnt == 0) begin
        addr_log.push_back(mem_address);
        if (mem_write) mem[mem_address] = mem_write_data;
      end
      if (mem_enable && hi_cnt == mem_delay) begin
        mem_response  = 1'b1;
        mem_read_data = model_read(mem_address);
      end else begin
        mem_response  = 1'b0;
        mem_read_data = 32'h5A5A_5A5A;
      end
      hi_cnt++;
    end else begin
      mem_response  = 1'b0;
      mem_read_data = 32'h5A5A_5A5A;
      hi_cnt        = 0;
    end
  end

  typedef struct packed { logic [W-1:0] data; bit chk; } exp_t;
  exp_t exp_ctrl_q [$];
  exp_t exp_core_q [$];
  int   resp_log   [$];
  int   n_ctrl_resp = 0, n_core_resp = 0, unexp_ctrl = 0, unexp_core = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && ctrl_response) begin
      n_ctrl_resp++;
      resp_log.push_back(0);
      if (exp_ctrl_q.size() == 0) unexp_ctrl++;
      else begin
        mon_e = exp_ctrl_q.pop_front();
        $display("ctrl response: data %08h mux %0d", ctrl_read_data, mux_selector);
        if (mon_e.chk) check("ctrl_read_data", ctrl_read_data, mon_e.data);
        check("ctrl_resp_mux", mux_selector, 0);
        check("ctrl_busy_in_resp", ctrl_busy, 0);
      end
    end
    if (!rst && core_response) begin
      n_core_resp++;
      resp_log.push_back(1);
      if (exp_core_q.size() == 0) unexp_core++;
      else begin
        mon_e = exp_core_q.pop_front();
        $display("core response: data %08h mux %0d", core_read_data, mux_selector);
        if (mon_e.chk) check("core_read_data", core_read_data, mon_e.data);
        check("core_resp_mux", mux_selector, 1);
        check("core_busy_in_resp", core_busy, 0);
      end
    end
  end

  int pc = 0;
  always @(posedge clk) pc++;

  task automatic expect_resp(bit side, bit chk, logic [W-1:0] d);
    exp_t e;
    e.data = d;
    e.chk  = chk;
    if (side) exp_core_q.push_back(e);
    else      exp_ctrl_q.push_back(e);
  endtask

  task automatic cmd(bit side, bit rd, bit wr, logic [W-1:0] a, logic [W-1:0] d);
    if (side) begin core_read = rd; core_write = wr; core_address = a; core_write_data = d; end
    else      begin ctrl_read = rd; ctrl_write = wr; ctrl_address = a; ctrl_write_data = d; end
    @(negedge clk);
    ctrl_read = 1'b0; ctrl_write = 1'b0; core_read = 1'b0; core_write = 1'b0;
  endtask

  task automatic wait_drain(string tag, int budget);
    for (int i = 0; i < budget && (exp_ctrl_q.size() + exp_core_q.size()) != 0; i++) @(negedge clk);
    check(tag, exp_ctrl_q.size() + exp_core_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, cnt, base_core;
    rst = 1'b1; ctrl_lock = 1'b0;
    ctrl_read = 1'b0; ctrl_write = 1'b0; ctrl_address = '0; ctrl_write_data = '0;
    core_read = 1'b0; core_write = 1'b0; core_address = '0; core_write_data = '0;
    mem_response = 1'b0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {mem_read, mem_write, ctrl_busy, core_busy, ctrl_response,
                            core_response, mux_selector, timeout_error}, 0);
    check("reset_mem_address", mem_address, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: controller read, answer 3 cycles after strobe.
    mem[32'h10] = 32'hCAFE_BABE;
    mem_delay = 3;
    expect_resp(0, 1, 32'hCAFE_BABE);
    t0 = pc;
    cmd(0, 1, 0, 32'h10, 0);
    check("t1_busy_after_cmd", ctrl_busy, 1);
    for (int i = 0; i < 40 && !ctrl_response; i++) @(negedge clk);
    check("t1_latency", pc - t0, 6);
    wait_drain("t1_drain", 10);
    check("t1_addr", addr_log[addr_log.size()-1], 32'h10);

    // 2: simultaneous writes right after reset -> controller first.
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    resp_log.delete(); addr_log.delete();
    expect_resp(0, 0, 0);
    expect_resp(1, 0, 0);
    ctrl_write = 1'b1; ctrl_address = 32'h100; ctrl_write_data = 32'h1111_1111;
    core_write = 1'b1; core_address = 32'h200; core_write_data = 32'h2222_2222;
    @(negedge clk);
    ctrl_write = 1'b0; core_write = 1'b0;
    wait_drain("t2_drain", 100);
    check("t2_resp_count", resp_log.size(), 2);
    check("t2_first_ctrl", resp_log[0], 0);
    check("t2_second_core", resp_log[1], 1);
    check("t2_addr_order", {addr_log[0], addr_log[1]}, {32'h100, 32'h200});
    expect_resp(1, 1, 32'h1111_1111);
    cmd(1, 1, 0, 32'h100, 0);
    wait_drain("t2_readback", 50);
    // Read and write together behave as a write.
    expect_resp(0, 0, 0);
    cmd(0, 1, 1, 32'h300, 32'h3333_3333);
    wait_drain("t2_rw_drain", 50);
    expect_resp(1, 1, 32'h3333_3333);
    cmd(1, 1, 0, 32'h300, 0);
    wait_drain("t2_rw_readback", 50);

    // 3: lock holds the core off while three controller reads go through.
    ctrl_lock = 1'b1;
    @(negedge clk);
    base_core = n_core_resp;
    expect_resp(1, 0, 0);
    cmd(1, 0, 1, 32'h400, 32'h4444_4444);
    for (int k = 0; k < 3; k++) begin
      expect_resp(0, 1, model_read(32'h20 + 4 * k));
      cmd(0, 1, 0, 32'h20 + 4 * k, 0);
      for (int i = 0; i < 50 && exp_ctrl_q.size() != 0; i++) @(negedge clk);
      check("t3_ctrl_served", exp_ctrl_q.size(), 0);
      check("t3_core_busy", core_busy, 1);
    end
    repeat (10) @(negedge clk);
    check("t3_core_waits", {n_core_resp - base_core, 31'(0), mem_read, mem_write, core_busy}, 3'b001);
    ctrl_lock = 1'b0;
    wait_drain("t3_core_after_unlock", 50);
    check("t3_core_idle", core_busy, 0);
    expect_resp(0, 1, 32'h4444_4444);
    cmd(0, 1, 0, 32'h400, 0);
    wait_drain("t3_readback", 50);

    // 4: core read never answered -> abort after 360 strobe cycles.
    mem_enable = 1'b0;
    expect_resp(1, 1, 0);
    cmd(1, 1, 0, 32'h500, 0);
    for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
    cnt = 0;
    while (mem_read && cnt < 500) begin cnt++; @(negedge clk); end
    check("t4_strobe_cycles", cnt, 360);
    wait_drain("t4_drain", 5);
    check("t4_timeout_error", timeout_error, 1);
    mem_enable = 1'b1;
    expect_resp(0, 1, model_read(32'h510));
    cmd(0, 1, 0, 32'h510, 0);
    wait_drain("t4_after", 50);
    check("t4_timeout_sticky", timeout_error, 1);

    // 5: second core pulse while busy is ignored.
    mem_delay = 5;
    addr_log.delete();
    expect_resp(1, 1, model_read(32'h600));
    cmd(1, 1, 0, 32'h600, 0);
    check("t5_busy_before_second", core_busy, 1);
    cmd(1, 1, 0, 32'h700, 0);
    wait_drain("t5_drain", 50);
    repeat (20) @(negedge clk);
    check("t5_addr_count", addr_log.size(), 1);
    check("t5_addr_first", addr_log[0], 32'h600);

    // 6: reset while a write strobe is high.
    mem_enable = 1'b0;
    base_core = n_core_resp + n_ctrl_resp;
    cmd(0, 0, 1, 32'h800, 32'hABAB_ABAB);
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    check("t6_write_strobe", mem_write, 1);
    cmd(1, 0, 1, 32'h900, 32'h9999_9999);
    #2 rst = 1'b1;
    #1;
    check("t6_async_reset", {mem_read, mem_write, ctrl_busy, core_busy, mux_selector, timeout_error}, 0);
    check("t6_async_addr", mem_address, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_enable = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_response", n_core_resp + n_ctrl_resp - base_core, 0);
    check("t6_idle", {mem_read, mem_write, ctrl_busy, core_busy}, 0);

    check("unexpected_ctrl", unexp_ctrl, 0);
    check("unexpected_core", unexp_core, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
